// File: rtl/approx_adder_pipe.sv
// Pipelined unsigned adder with run-time selectable low-bit approximation (exact / LOA / truncate).
// An exact sum travels alongside each result to flag approximation error and feed saturating stats.
module approx_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 2,
    parameter int APPROX_BITS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y,
    output logic             out_err,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [SEG:0]     LO_MASK_W = ({{SEG{1'b0}}, 1'b1} << APPROX_BITS) - {{SEG{1'b0}}, 1'b1};
    localparam logic [SEG-1:0]   LO_MASK   = LO_MASK_W[SEG-1:0];
    // Single-bit mask on bit L-1; zero when no bits are approximated.
    localparam logic [SEG-1:0]   TOP_MASK  = LO_MASK ^ (LO_MASK >> 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] ready_s;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH:0]    y_r [STAGES];
    logic [WIDTH:0]    e_r [STAGES];
    logic              out_err_r;
    logic [CNT_W-1:0]  txn_r;
    logic [CNT_W-1:0]  err_r;
    logic              handoff_s;

    // First segment with the approximated low part; returns {carry_out, sum}.
    function automatic logic [SEG:0] seg0_sum(input logic [SEG-1:0] sa,
                                              input logic [SEG-1:0] sb,
                                              input logic [1:0]     md);
        logic [SEG:0]   hi_v;
        logic [SEG-1:0] lo_v;
        logic           cin_v;
        logic           apx_v;
        hi_v  = '0;
        lo_v  = '0;
        cin_v = 1'b0;
        apx_v = 1'b0;
        case (md)
            2'b01: begin
                apx_v = 1'b1;
                cin_v = |(sa & sb & TOP_MASK);
                lo_v  = (sa | sb) & LO_MASK;
            end
            2'b10: begin
                apx_v = 1'b1;
                cin_v = 1'b0;
                lo_v  = '0;
            end
            default: begin
                apx_v = 1'b0;
                cin_v = 1'b0;
                lo_v  = '0;
            end
        endcase
        if (apx_v) begin
            hi_v = {1'b0, sa & ~LO_MASK} + {1'b0, sb & ~LO_MASK} + ({{SEG{1'b0}}, cin_v} << APPROX_BITS);
        end else begin
            hi_v = {1'b0, sa} + {1'b0, sb};
        end
        return hi_v | {1'b0, lo_v};
    endfunction

    // Backpressure chain: a stage can load when empty or when its successor can load.
    always_comb begin
        logic rdy_v;
        rdy_v   = out_ready;
        ready_s = '0;
        for (int k = LAST; k >= 0; k--) begin
            rdy_v      = !v_r[k] | rdy_v;
            ready_s[k] = rdy_v;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vin_s;
        logic [WIDTH-1:0] ain_s;
        logic [WIDTH-1:0] bin_s;
        logic [WIDTH:0]   yin_s;
        logic [WIDTH:0]   ein_s;
        logic [WIDTH:0]   y_nx_s;
        logic [WIDTH:0]   e_nx_s;
        logic [SEG:0]     sy_s;
        logic [SEG:0]     se_s;

        if (k == 0) begin : g_src
            assign vin_s = in_valid;
            assign ain_s = a;
            assign bin_s = b;
            assign yin_s = '0;
            assign ein_s = '0;
            assign sy_s  = seg0_sum(a[SEG-1:0], b[SEG-1:0], mode);
        end else begin : g_src
            assign vin_s = v_r[k-1];
            assign ain_s = a_r[k-1];
            assign bin_s = b_r[k-1];
            assign yin_s = y_r[k-1];
            assign ein_s = e_r[k-1];
            assign sy_s  = {1'b0, ain_s[k*SEG +: SEG]} + {1'b0, bin_s[k*SEG +: SEG]} + {{SEG{1'b0}}, yin_s[WIDTH]};
        end

        // Carry of the previous stage rides in bit WIDTH of the partial sums.
        assign se_s = {1'b0, ain_s[k*SEG +: SEG]} + {1'b0, bin_s[k*SEG +: SEG]} + {{SEG{1'b0}}, ein_s[WIDTH]};

        // Splice this stage's segment and carry into the running approximate and exact sums.
        always_comb begin
            y_nx_s               = yin_s;
            e_nx_s               = ein_s;
            y_nx_s[k*SEG +: SEG] = sy_s[SEG-1:0];
            y_nx_s[WIDTH]        = sy_s[SEG];
            e_nx_s[k*SEG +: SEG] = se_s[SEG-1:0];
            e_nx_s[WIDTH]        = se_s[SEG];
        end

        // Stage register: advances when it can accept; payload captured only with a valid token.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                y_r[k] <= '0;
                e_r[k] <= '0;
            end else if (ready_s[k]) begin
                v_r[k] <= vin_s;
                if (vin_s) begin
                    a_r[k] <= ain_s;
                    b_r[k] <= bin_s;
                    y_r[k] <= y_nx_s;
                    e_r[k] <= e_nx_s;
                end
            end
        end

        if (k == LAST) begin : g_err
            // Error flag registered together with the final result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_err_r <= 1'b0;
                end else if (ready_s[k] && vin_s) begin
                    out_err_r <= (y_nx_s != e_nx_s);
                end
            end
        end
    end

    assign handoff_s = v_r[LAST] & out_ready;

    // Saturating handoff statistics; a clear beats a simultaneous handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_r <= '0;
            err_r <= '0;
        end else if (clr_stats) begin
            txn_r <= '0;
            err_r <= '0;
        end else if (handoff_s) begin
            if (txn_r != CNT_MAX) begin
                txn_r <= txn_r + CNT_ONE;
            end
            if (out_err_r && (err_r != CNT_MAX)) begin
                err_r <= err_r + CNT_ONE;
            end
        end
    end

    assign in_ready  = ready_s[0];
    assign out_valid = v_r[LAST];
    assign y         = y_r[LAST];
    assign out_err   = out_err_r;
    assign txn_cnt   = txn_r;
    assign err_cnt   = err_r;

endmodule
